matmul_seq_unit: RTL and testbench
==================================

MATMUL_SEQ_UNIT -- requirements
Module: matmul_seq_unit

Interface
REQ-001 Parameter DSTW, default 10, destination register index width.
REQ-002 Parameter MASKW, default 4, vector lane mask width.
REQ-003 Parameter NSTAGE, default 32, number of registered writeback pipe stages; legal range 2..64.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 activate  input  1  matmul issue request from the vector lane.
REQ-007 en  input  NSTAGE [NSTAGE:1]  per-pipestage enable.
REQ-008 squash  input  NSTAGE [NSTAGE:1]  per-pipestage squash.
REQ-009 in_dst  input  DSTW  destination register index.
REQ-010 in_dst_we  input  1  destination write enable.
REQ-011 vmask  input  MASKW  lane mask of the instruction.
REQ-012 eng_done  input  1  one-cycle completion pulse from the systolic engine.
REQ-013 eng_start  output  1  one-cycle start pulse to the systolic engine.
REQ-014 stall  output  1  backpressure to the lane pipeline.
REQ-015 pend_valid  output  1  one request is parked in the pending slot.
REQ-016 out_dst  output  (NSTAGE+1)*DSTW  stage 0..NSTAGE destination indices, stage k at bits [k*DSTW +: DSTW].
REQ-017 out_dst_we  output  NSTAGE+1  stage 0..NSTAGE write enables.
REQ-018 out_dst_mask  output  (NSTAGE+1)*MASKW  stage 0..NSTAGE lane masks.

Function
REQ-019 FSM states IDLE, ISSUE, RUN; eng_start SHALL be 1 only in ISSUE.
REQ-020 Accept condition: activate & en[1] & ~squash[1] & ~stall.
REQ-021 IDLE: accept -> ISSUE; otherwise hold IDLE.
REQ-022 ISSUE -> RUN unconditionally after exactly one cycle; an accept in ISSUE loads the pending slot.
REQ-023 RUN, no eng_done: accept loads the pending slot (pend_valid <= 1).
REQ-024 RUN, eng_done, pend_valid=1: -> ISSUE, pend_valid <= 0.
REQ-025 RUN, eng_done, pend_valid=0, accept same cycle: -> ISSUE directly; pending slot stays empty.
REQ-026 RUN, eng_done, pend_valid=0, no accept: -> IDLE.
REQ-027 eng_done in IDLE or ISSUE is ignored.
REQ-028 stall = pend_valid (combinational from register); activate while stall=1 is not accepted and upstream holds it.
REQ-029 Stage 0 of out_dst/out_dst_we/out_dst_mask is combinational pass-through of in_dst/in_dst_we/vmask.
REQ-030 Stage k (1..NSTAGE) loads stage k-1 when stage enable is 1; stage enable = en[k] & ~stall for k<NSTAGE, en[NSTAGE] for k=NSTAGE.
REQ-031 squash[k]=1 clears out_dst_we stage k to 0 at the clock edge, taking priority over load; dst and mask stages are not squashed.
REQ-032 Stages with enable 0 and no squash hold their value.

Reset
REQ-033 resetn=0 SHALL immediately force FSM to IDLE and clear eng_start, pend_valid, stall, and all registered stages 1..NSTAGE of dst, we, mask to 0.
REQ-034 Reset during ISSUE or RUN abandons the operation; any later eng_done is ignored per REQ-027.

Verification
REQ-035 Reset, activate=1, en=all-1 for one cycle -> eng_start=1 on next cycle only, state RUN, stall=0.
REQ-036 In RUN, second activate accepted -> pend_valid=1, stall=1; eng_done -> eng_start pulses next cycle, pend_valid=0.
REQ-037 In RUN, eng_done and activate same cycle with pend_valid=0 -> eng_start next cycle, pend_valid stays 0.
REQ-038 in_dst=0x2A, in_dst_we=1, vmask=0xF, en=all-1, stall=0 -> out_dst stage 3 = 0x2A after 3 edges; squash[2]=1 on edge 2 -> out_dst_we stage 2 and stage 3 (one edge later) = 0.
REQ-039 stall=1 with en=all-1 -> stages 1..NSTAGE-1 frozen, stage NSTAGE still loads stage NSTAGE-1.
REQ-040 resetn driven low mid-RUN with pend_valid=1 -> all outputs 0 asynchronously; eng_done after release produces no eng_start.

Source files
------------

// File: rtl/matmul_seq_unit.sv
// Sequencer that hands matmul issues to a systolic engine. It holds one request in a
// pending slot and carries destination/we/mask down a registered writeback pipe.

module matmul_seq_stage #(
  parameter int DSTW  = 10,
  parameter int MASKW = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ld,
  input  logic             sq,
  input  logic [DSTW-1:0]  dst_i,
  input  logic             we_i,
  input  logic [MASKW-1:0] mask_i,
  output logic [DSTW-1:0]  dst_o,
  output logic             we_o,
  output logic [MASKW-1:0] mask_o
);
  logic [DSTW-1:0]  dst_d, dst_q;
  logic             we_d, we_q;
  logic [MASKW-1:0] mask_d, mask_q;

  // Squash only kills the write enable; dst/mask follow the normal load/hold path.
  always_comb begin
    dst_d  = ld ? dst_i  : dst_q;
    mask_d = ld ? mask_i : mask_q;
    we_d   = sq ? 1'b0 : (ld ? we_i : we_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dst_q  <= '0;
      we_q   <= 1'b0;
      mask_q <= '0;
    end else begin
      dst_q  <= dst_d;
      we_q   <= we_d;
      mask_q <= mask_d;
    end
  end

  assign dst_o  = dst_q;
  assign we_o   = we_q;
  assign mask_o = mask_q;
endmodule

module matmul_seq_unit #(
  parameter int DSTW   = 10,
  parameter int MASKW  = 4,
  parameter int NSTAGE = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          activate,
  input  logic [NSTAGE:1]               en,
  input  logic [NSTAGE:1]               squash,
  input  logic [DSTW-1:0]               in_dst,
  input  logic                          in_dst_we,
  input  logic [MASKW-1:0]              vmask,
  input  logic                          eng_done,
  output logic                          eng_start,
  output logic                          stall,
  output logic                          pend_valid,
  output logic [(NSTAGE+1)*DSTW-1:0]    out_dst,
  output logic [NSTAGE:0]               out_dst_we,
  output logic [(NSTAGE+1)*MASKW-1:0]   out_dst_mask
);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t state_d, state_q;
  logic   pend_d, pend_q;
  logic   eng_start_d, eng_start_q;
  logic   accept;

  assign stall  = pend_q;
  assign accept = activate & en[1] & ~squash[1] & ~stall;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        state_d = RUN;
        if (accept) pend_d = 1'b1;
      end
      RUN: begin
        if (eng_done) begin
          // A parked request wins; else a same-cycle accept goes straight to issue.
          if (pend_q) begin
            state_d = ISSUE;
            pend_d  = 1'b0;
          end else if (accept) begin
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    eng_start_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      eng_start_q <= eng_start_d;
    end
  end

  assign eng_start  = eng_start_q;
  assign pend_valid = pend_q;

  logic [NSTAGE:0][DSTW-1:0]  dst_pipe;
  logic [NSTAGE:0]            we_pipe;
  logic [NSTAGE:0][MASKW-1:0] mask_pipe;

  assign dst_pipe[0]  = in_dst;
  assign we_pipe[0]   = in_dst_we;
  assign mask_pipe[0] = vmask;

  // The last stage drains independently of stall so writeback never backs up.
  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    logic ld;
    if (k == NSTAGE) begin : g_last
      assign ld = en[k];
    end else begin : g_mid
      assign ld = en[k] & ~stall;
    end
    matmul_seq_stage #(.DSTW(DSTW), .MASKW(MASKW)) u_stage (
      .clk    (clk),
      .resetn (resetn),
      .ld     (ld),
      .sq     (squash[k]),
      .dst_i  (dst_pipe[k-1]),
      .we_i   (we_pipe[k-1]),
      .mask_i (mask_pipe[k-1]),
      .dst_o  (dst_pipe[k]),
      .we_o   (we_pipe[k]),
      .mask_o (mask_pipe[k])
    );
  end

  assign out_dst      = dst_pipe;
  assign out_dst_we   = we_pipe;
  assign out_dst_mask = mask_pipe;
endmodule

// File: tb/tb_matmul_seq_unit.sv
// Directed bench for matmul_seq_unit: FSM sequencing, pending slot, writeback pipe, reset.

module tb_matmul_seq_unit;
  localparam int NS = 4;
  localparam int DW = 10;
  localparam int MW = 4;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  activate;
  logic [NS:1]           en;
  logic [NS:1]           squash;
  logic [DW-1:0]         in_dst;
  logic                  in_dst_we;
  logic [MW-1:0]         vmask;
  logic                  eng_done;
  logic                  eng_start;
  logic                  stall;
  logic                  pend_valid;
  logic [(NS+1)*DW-1:0]  out_dst;
  logic [NS:0]           out_dst_we;
  logic [(NS+1)*MW-1:0]  out_dst_mask;

  int n_tests = 0;
  int n_fail  = 0;

  matmul_seq_unit #(.DSTW(DW), .MASKW(MW), .NSTAGE(NS)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .activate     (activate),
    .en           (en),
    .squash       (squash),
    .in_dst       (in_dst),
    .in_dst_we    (in_dst_we),
    .vmask        (vmask),
    .eng_done     (eng_done),
    .eng_start    (eng_start),
    .stall        (stall),
    .pend_valid   (pend_valid),
    .out_dst      (out_dst),
    .out_dst_we   (out_dst_we),
    .out_dst_mask (out_dst_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sd(int k);
    return 64'(out_dst[k*DW +: DW]);
  endfunction
  function automatic logic [63:0] sw(int k);
    return 64'(out_dst_we[k]);
  endfunction
  function automatic logic [63:0] sm(int k);
    return 64'(out_dst_mask[k*MW +: MW]);
  endfunction

  initial begin
    resetn = 1'b0; activate = 1'b0; en = '0; squash = '0;
    in_dst = '0; in_dst_we = 1'b0; vmask = '0; eng_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 64'(eng_start), 64'h0);
    check("rst_pend",  64'(pend_valid), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_we",    64'(out_dst_we), 64'h0);
    check("rst_dst",   64'(out_dst), 64'h0);
    check("rst_mask",  64'(out_dst_mask), 64'h0);
    resetn = 1'b1; en = '1;

    // First issue: pulse one cycle after accept, then RUN.
    activate = 1'b1; step(); activate = 1'b0;
    check("issue_start", 64'(eng_start), 64'h1);
    check("issue_stall", 64'(stall), 64'h0);
    step();
    check("run_start_lo", 64'(eng_start), 64'h0);
    check("run_stall",    64'(stall), 64'h0);

    // Second request parks; held while stalled; released by done.
    activate = 1'b1; step(); activate = 1'b0;
    check("park_pend",  64'(pend_valid), 64'h1);
    check("park_stall", 64'(stall), 64'h1);
    check("park_start", 64'(eng_start), 64'h0);
    activate = 1'b1; step(); activate = 1'b0;
    check("stall_hold_pend",  64'(pend_valid), 64'h1);
    check("stall_hold_start", 64'(eng_start), 64'h0);
    eng_done = 1'b1; step(); eng_done = 1'b0;
    check("pend_issue_start", 64'(eng_start), 64'h1);
    check("pend_issue_clear", 64'(pend_valid), 64'h0);
    step();
    check("pend_run_start_lo", 64'(eng_start), 64'h0);

    // Done plus accept with empty slot goes straight to issue.
    eng_done = 1'b1; activate = 1'b1; step(); eng_done = 1'b0; activate = 1'b0;
    check("direct_start", 64'(eng_start), 64'h1);
    check("direct_pend",  64'(pend_valid), 64'h0);
    step();
    check("direct_run", 64'(eng_start), 64'h0);

    // Done without accept returns to IDLE; done in IDLE is ignored.
    eng_done = 1'b1; step();
    check("to_idle", 64'(eng_start), 64'h0);
    step();
    check("idle_done_ignored", 64'(eng_start), 64'h0);
    eng_done = 1'b0;

    // Accept blocked by squash[1] or en[1]=0.
    activate = 1'b1; squash[1] = 1'b1; step(); squash = '0;
    check("blk_squash", 64'(eng_start), 64'h0);
    en[1] = 1'b0; step(); en = '1;
    check("blk_en", 64'(eng_start), 64'h0);
    step(); activate = 1'b0;
    check("idle_accept", 64'(eng_start), 64'h1);
    step();
    eng_done = 1'b1; step(); eng_done = 1'b0;
    check("back_idle", 64'(eng_start), 64'h0);

    // Writeback pipe: 0x2A travels down, squash[2] kills its we at stage 2.
    in_dst = 10'h2A; in_dst_we = 1'b1; vmask = 4'hF; #1;
    check("s0_pass", sd(0), 64'h2A);
    step();
    check("s1_dst", sd(1), 64'h2A);
    check("s1_we",  sw(1), 64'h1);
    in_dst = 10'h11; vmask = 4'h3; squash[2] = 1'b1; step(); squash = '0;
    check("s2_dst",  sd(2), 64'h2A);
    check("s2_we_sq", sw(2), 64'h0);
    check("s2_mask", sm(2), 64'hF);
    check("s1_next", sd(1), 64'h11);
    in_dst = '0; in_dst_we = 1'b0; vmask = '0; step();
    check("s3_dst",  sd(3), 64'h2A);
    check("s3_we",   sw(3), 64'h0);
    check("s3_mask", sm(3), 64'hF);
    check("s2_we_next", sw(2), 64'h1);

    // Build a 4,3,2,1 gradient while parking a request in ISSUE, then stall.
    in_dst_we = 1'b1;
    in_dst = 10'd1; step();
    in_dst = 10'd2; step();
    in_dst = 10'd3; activate = 1'b1; step();
    in_dst = 10'd4; step(); activate = 1'b0;
    check("issue_park_pend", 64'(pend_valid), 64'h1);
    check("grad_s4", sd(4), 64'h1);
    in_dst = 10'd9; step();
    check("frz_s1", sd(1), 64'h4);
    check("frz_s2", sd(2), 64'h3);
    check("frz_s3", sd(3), 64'h2);
    check("drain_s4", sd(4), 64'h2);

    // Asynchronous reset mid-RUN with a parked request.
    #2 resetn = 1'b0; #1;
    check("arst_start", 64'(eng_start), 64'h0);
    check("arst_pend",  64'(pend_valid), 64'h0);
    check("arst_stall", 64'(stall), 64'h0);
    check("arst_dst",   64'(out_dst >> DW), 64'h0);
    check("arst_we",    64'(out_dst_we >> 1), 64'h0);
    check("arst_mask",  64'(out_dst_mask >> MW), 64'h0);
    @(negedge clk); resetn = 1'b1; eng_done = 1'b1;
    step();
    check("post_rst_done1", 64'(eng_start), 64'h0);
    step(); eng_done = 1'b0;
    check("post_rst_done2", 64'(eng_start), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
